// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and LSU writebacks.
// Each source has a one-entry slot and the granted slot feeds a registered write stage.
module regfile_wb_arbiter #(
  parameter int unsigned LSU_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd_select,
  input  logic [31:0] alu_rd,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd_select,
  input  logic [31:0] lsu_rd,
  output logic        reg_rd_valid,
  output logic [4:0]  reg_rd_select,
  output logic [31:0] reg_rd,
  output logic [31:0] pending_mask
);

  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              alu_full, alu_older;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_full, lsu_older;
  logic [SEL_W-1:0]  lsu_sel;
  logic [DATA_W-1:0] lsu_data;
  logic              rr_lsu_last;

  logic gnt_alu, gnt_lsu, both_full, same_rd;
  logic alu_fill, lsu_fill;

  // Grant from slot state only; same-register conflicts follow age, not policy
  always_comb begin
    gnt_alu   = 1'b0;
    gnt_lsu   = 1'b0;
    both_full = alu_full && lsu_full;
    same_rd   = (alu_sel == lsu_sel);
    if (both_full) begin
      if (same_rd) begin
        if (alu_older) gnt_alu = 1'b1;
        else           gnt_lsu = 1'b1;
      end else if (LSU_PRIORITY != 0) begin
        gnt_lsu = 1'b1;
      end else if (rr_lsu_last) begin
        gnt_alu = 1'b1;
      end else begin
        gnt_lsu = 1'b1;
      end
    end else begin
      gnt_alu = alu_full;
      gnt_lsu = lsu_full;
    end
  end

  assign alu_ready = !rst && (!alu_full || gnt_alu);
  assign lsu_ready = !rst && (!lsu_full || gnt_lsu);

  // Writes to x0 complete the handshake but never occupy a slot
  assign alu_fill = alu_valid && alu_ready && (alu_rd_select != SEL_W'(0));
  assign lsu_fill = lsu_valid && lsu_ready && (lsu_rd_select != SEL_W'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_full      <= 1'b0;
      alu_older     <= 1'b0;
      alu_sel       <= '0;
      alu_data      <= '0;
      lsu_full      <= 1'b0;
      lsu_older     <= 1'b0;
      lsu_sel       <= '0;
      lsu_data      <= '0;
      rr_lsu_last   <= 1'b1;
      reg_rd_valid  <= 1'b0;
      reg_rd_select <= '0;
      reg_rd        <= '0;
    end else begin
      if (alu_fill) begin
        alu_full  <= 1'b1;
        alu_older <= 1'b0;
        alu_sel   <= alu_rd_select;
        alu_data  <= alu_rd;
      end else if (gnt_alu) begin
        alu_full  <= 1'b0;
        alu_older <= 1'b0;
      end else if (lsu_fill && alu_full) begin
        alu_older <= 1'b1;
      end

      if (lsu_fill) begin
        lsu_full  <= 1'b1;
        lsu_older <= 1'b0;
        lsu_sel   <= lsu_rd_select;
        lsu_data  <= lsu_rd;
      end else if (gnt_lsu) begin
        lsu_full  <= 1'b0;
        lsu_older <= 1'b0;
      end else if (alu_fill && lsu_full) begin
        lsu_older <= 1'b1;
      end

      // Round-robin pointer only moves on contested, different-register grants
      if (both_full && !same_rd) rr_lsu_last <= gnt_lsu;

      reg_rd_valid <= gnt_alu || gnt_lsu;
      if (gnt_alu) begin
        reg_rd_select <= alu_sel;
        reg_rd        <= alu_data;
      end else if (gnt_lsu) begin
        reg_rd_select <= lsu_sel;
        reg_rd        <= lsu_data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (alu_full)     pending_mask[alu_sel]       = 1'b1;
    if (lsu_full)     pending_mask[lsu_sel]       = 1'b1;
    if (reg_rd_valid) pending_mask[reg_rd_select] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (round-robin instance),
// plus a hand-written sequence for the LSU-priority instance.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd_select, lsu_rd_select;
  logic [31:0] alu_rd, lsu_rd;

  logic        alu_ready0, lsu_ready0, reg_rd_valid0;
  logic [4:0]  reg_rd_select0;
  logic [31:0] reg_rd0, pending_mask0;
  logic        alu_ready1, lsu_ready1, reg_rd_valid1;
  logic [4:0]  reg_rd_select1;
  logic [31:0] reg_rd1, pending_mask1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.LSU_PRIORITY(0)) dut0 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready0),
    .alu_rd_select(alu_rd_select), .alu_rd(alu_rd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready0),
    .lsu_rd_select(lsu_rd_select), .lsu_rd(lsu_rd),
    .reg_rd_valid(reg_rd_valid0), .reg_rd_select(reg_rd_select0),
    .reg_rd(reg_rd0), .pending_mask(pending_mask0)
  );

  regfile_wb_arbiter #(.LSU_PRIORITY(1)) dut1 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready1),
    .alu_rd_select(alu_rd_select), .alu_rd(alu_rd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready1),
    .lsu_rd_select(lsu_rd_select), .lsu_rd(lsu_rd),
    .reg_rd_valid(reg_rd_valid1), .reg_rd_select(reg_rd_select1),
    .reg_rd(reg_rd1), .pending_mask(pending_mask1)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  as;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  ls;
    logic [31:0] ld;
    logic        ev;
    logic [4:0]  es;
    logic [31:0] ed;
    logic [31:0] em;
    logic        ear;
    logic        elr;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int i, input logic r,
                     input logic av, input logic [4:0] as, input logic [31:0] ad,
                     input logic lv, input logic [4:0] ls, input logic [31:0] ld,
                     input logic ev, input logic [4:0] es, input logic [31:0] ed,
                     input logic [31:0] em, input logic ear, input logic elr);
    vecs[i].rst = r;
    vecs[i].av = av; vecs[i].as = as; vecs[i].ad = ad;
    vecs[i].lv = lv; vecs[i].ls = ls; vecs[i].ld = ld;
    vecs[i].ev = ev; vecs[i].es = es; vecs[i].ed = ed;
    vecs[i].em = em; vecs[i].ear = ear; vecs[i].elr = elr;
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] as, input logic [31:0] ad,
                       input logic lv, input logic [4:0] ls, input logic [31:0] ld);
    rst = r;
    alu_valid = av; alu_rd_select = as; alu_rd = ad;
    lsu_valid = lv; lsu_rd_select = ls; lsu_rd = ld;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Row i: inputs held during cycle i; expectations observed in cycle i
    put(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0);
    put(1, 0, 1, 5, 32'h1234_5678, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h20, 1, 1);
    put(3, 0, 0, 0, 0, 0, 0, 0,  1, 5, 32'h1234_5678, 32'h20, 1, 1);
    put(4, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      logic [31:0] m;
      m = 32'h0;
      if (k >= 2) m = m | (32'h1 << (k - 1));
      if (k >= 3) m = m | (32'h1 << (k - 2));
      put(4 + k, 0, 1, 5'(k), 32'h100 + 32'(k), 0, 0, 0,
          (k >= 3), 5'(k - 2), 32'h100 + 32'(k - 2), m, 1, 1);
    end
    put(13, 0, 0, 0, 0, 0, 0, 0,  1, 7, 32'h107, 32'h180, 1, 1);
    put(14, 0, 0, 0, 0, 0, 0, 0,  1, 8, 32'h108, 32'h100, 1, 1);
    put(15, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(16, 0, 1, 3, 32'h33, 1, 4, 32'h44,  0, 0, 0, 32'h0, 1, 1);
    put(17, 0, 1, 3, 32'h33, 1, 4, 32'h44,  0, 0, 0, 32'h18, 1, 0);
    put(18, 0, 1, 3, 32'h33, 1, 4, 32'h44,  1, 3, 32'h33, 32'h18, 0, 1);
    put(19, 0, 1, 3, 32'h33, 1, 4, 32'h44,  1, 4, 32'h44, 32'h18, 1, 0);
    put(20, 0, 0, 0, 0, 0, 0, 0,  1, 3, 32'h33, 32'h18, 0, 1);
    put(21, 0, 0, 0, 0, 0, 0, 0,  1, 4, 32'h44, 32'h18, 1, 1);
    put(22, 0, 0, 0, 0, 0, 0, 0,  1, 3, 32'h33, 32'h08, 1, 1);
    put(23, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(24, 0, 1, 7, 32'hA, 1, 7, 32'hB,  0, 0, 0, 32'h0, 1, 1);
    put(25, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h80, 0, 1);
    put(26, 0, 0, 0, 0, 0, 0, 0,  1, 7, 32'hB, 32'h80, 1, 1);
    put(27, 0, 0, 0, 0, 0, 0, 0,  1, 7, 32'hA, 32'h80, 1, 1);
    put(28, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(29, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(30, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(31, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(32, 0, 1, 9, 32'h99, 1, 10, 32'hAA,  0, 0, 0, 32'h0, 1, 1);
    put(33, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h600, 0, 0);
    put(34, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);
    put(35, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_sel0", 32'(reg_rd_select0), 32'h0);
    check("reset_data0", reg_rd0, 32'h0);
    check("reset_sel1", 32'(reg_rd_select1), 32'h0);
    check("reset_data1", reg_rd1, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].av, vecs[i].as, vecs[i].ad, vecs[i].lv, vecs[i].ls, vecs[i].ld);
      #1;
      check($sformatf("row%0d_valid", i), 32'(reg_rd_valid0), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("row%0d_sel", i), 32'(reg_rd_select0), 32'(vecs[i].es));
        check($sformatf("row%0d_data", i), reg_rd0, vecs[i].ed);
      end
      check($sformatf("row%0d_mask", i), pending_mask0, vecs[i].em);
      check($sformatf("row%0d_alu_ready", i), 32'(alu_ready0), 32'(vecs[i].ear));
      check($sformatf("row%0d_lsu_ready", i), 32'(lsu_ready0), 32'(vecs[i].elr));
    end

    // LSU-priority instance: LSU rd=4 keeps winning while the ALU slot stalls
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check("p_rst_alu_ready", 32'(alu_ready1), 32'h0);
    check("p_rst_lsu_ready", 32'(lsu_ready1), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    #1;
    check("p0_alu_ready", 32'(alu_ready1), 32'h1);
    check("p0_valid", 32'(reg_rd_valid1), 32'h0);
    @(negedge clk);
    #1;
    check("p1_alu_ready", 32'(alu_ready1), 32'h0);
    check("p1_lsu_ready", 32'(lsu_ready1), 32'h1);
    check("p1_mask", pending_mask1, 32'h18);
    for (int p = 2; p <= 5; p++) begin
      @(negedge clk);
      #1;
      check($sformatf("p%0d_valid", p), 32'(reg_rd_valid1), 32'h1);
      check($sformatf("p%0d_sel", p), 32'(reg_rd_select1), 32'h4);
      check($sformatf("p%0d_data", p), reg_rd1, 32'h44);
      check($sformatf("p%0d_alu_ready", p), 32'(alu_ready1), 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check("p6_sel", 32'(reg_rd_select1), 32'h4);
    check("p6_alu_ready", 32'(alu_ready1), 32'h0);
    @(negedge clk);
    #1;
    check("p7_sel", 32'(reg_rd_select1), 32'h4);
    check("p7_alu_ready", 32'(alu_ready1), 32'h1);
    @(negedge clk);
    #1;
    check("p8_valid", 32'(reg_rd_valid1), 32'h1);
    check("p8_sel", 32'(reg_rd_select1), 32'h3);
    check("p8_data", reg_rd1, 32'h33);
    @(negedge clk);
    #1;
    check("p9_valid", 32'(reg_rd_valid1), 32'h0);
    check("p9_mask", pending_mask1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (reg_rd_valid / reg_rd_select / reg_rd) between two writeback sources: the ALU and the load/store unit (LSU).
- Each source has a valid/ready handshake and a one-entry holding slot. A round-robin or fixed-priority arbiter drains the slots into a registered write-port stage.
- Exports a pending-write mask so issue logic can detect RAW/WAW hazards on registers whose writes have not yet committed.

Parameters:
- LSU_PRIORITY, 0: 0 = round-robin between sources; 1 = LSU always wins when both slots are full.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready
- alu_rd_select  in  5  ALU destination register index
- alu_rd  in  32  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU handshake ready
- lsu_rd_select  in  5  LSU destination register index
- lsu_rd  in  32  LSU load data
- reg_rd_valid  out  1  register file write enable (registered)
- reg_rd_select  out  5  register file write index (registered)
- reg_rd  out  32  register file write data (registered)
- pending_mask  out  32  bit i = write to register i held in a slot or the output stage

Behaviour:
- Reset:
  - Both slots are emptied and their age flags cleared.
  - reg_rd_valid=0, reg_rd_select=0, reg_rd=0, pending_mask=0.
  - The round-robin pointer is set to favour the ALU.
  - alu_ready=lsu_ready=0 while rst=1.
  - Reset mid-operation discards all held writes; nothing reaches the register file after reset asserts.
- Slot per source: {full, rd_select, data, older}.
  - Handshake at edge E fills the slot if rd_select!=0.
  - A handshake with rd_select==0 is accepted and dropped: the slot stays empty, no write is ever produced, and no mask bit is set.
- Ready:
  - src_ready = !rst && (!slot_full || slot_granted_this_cycle).
  - ready has no combinational dependence on any *_valid input.
  - Sustains one write per cycle from a single source.
- Grant, evaluated each cycle from slot state only:
  - Exactly one full slot: that slot is granted.
  - Both full, different rd: with LSU_PRIORITY=0, grant the source not granted last time the pointer updated; with LSU_PRIORITY=1, grant the LSU. The pointer updates only on contested grants.
  - Both full, same rd: grant the slot with older=1, overriding policy. If both were filled on the same edge, the LSU goes first and the ALU second, so the ALU value is final.
- Older flag: set on fill if the other slot is full at that edge and is not being granted.
- Latency:
  - Handshake at edge E → slot full → granted at edge E+1 → reg_rd_valid=1 with the entry's select/data during the cycle after E+1.
  - The register file commits at edge E+2.
- Output stage: loads every cycle. reg_rd_valid = any grant; select/data hold their previous values when there is no grant.
- pending_mask: combinational OR of one-hot(rd_select) over full slots and the output stage when reg_rd_valid=1. Bit 0 is always 0.
- The ungranted full slot keeps its contents, its ready stays 0, and a new request from that source waits.
- Simultaneous fill of a slot and grant of the same slot at the same edge: the old entry moves to the output stage and the new entry occupies the slot.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0x1234_5678 at edge 1 → reg_rd_valid=1, select=5, reg_rd=0x12345678 in the cycle after edge 2. pending_mask bit5 is high from after edge 1 through the cycle after edge 2, and low after edge 3.
- ALU streams rd=1..8 on consecutive cycles, alu_valid held high → alu_ready stays 1, and eight consecutive reg_rd_valid pulses appear in order 1..8.
- Both sources valid every cycle, LSU_PRIORITY=0, ALU rd=3, LSU rd=4 → the write sequence alternates 3,4,3,4. With LSU_PRIORITY=1 → 4 repeats and ALU writes stall, with alu_ready=0 while its slot is full.
- ALU and LSU both present rd=7 on the same edge, ALU=0xA, LSU=0xB → the write of 0xB precedes 0xA, and the final register value is 0xA.
- ALU rd=0, data=0xFFFF_FFFF → handshake completes (alu_ready=1), no reg_rd_valid pulse, pending_mask stays 0.
- Both slots full, rst asserted for one cycle → no reg_rd_valid afterwards, pending_mask=0, both ready=0 during rst and 1 the cycle after.
